// File: rtl/gamma_pkg.sv
// rtl/gamma_pkg.sv - shared widths, ROM latency and helpers for the gamma LUT arbiter
package gamma_pkg;

    localparam int LUT_AW        = 8;
    localparam int LUT_DW        = 8;
    localparam int GAMMA_ROM_LAT = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter
    import gamma_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        req,
    input  logic [clog2(N)-1:0] ptr,
    output logic [N-1:0]        grant,
    output logic [clog2(N)-1:0] idx
);

    localparam int IW = clog2(N);

    logic [IW:0] slot;
    logic        found;

    // Walk slots ptr, ptr+1, ... modulo N; the first requester seen wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < N; k++) begin
            slot = {1'b0, ptr} + (IW+1)'(k);
            if (slot >= (IW+1)'(N)) slot = slot - (IW+1)'(N);
            if (!found && req[slot[IW-1:0]]) begin
                found                 = 1'b1;
                grant[slot[IW-1:0]]   = 1'b1;
                idx                   = slot[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/gamma_lut_arbiter.sv
// rtl/gamma_lut_arbiter.sv - round-robin sharing of one fixed-latency gamma LUT ROM
module gamma_lut_arbiter
    import gamma_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int AW      = LUT_AW,
    parameter int DW      = LUT_DW,
    parameter int ROM_LAT = GAMMA_ROM_LAT
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*AW-1:0]       req_addr_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic [AW-1:0]             lut_addr_o,
    input  logic [DW-1:0]             lut_data_i,
    output logic [N_REQ-1:0]          rsp_valid_o,
    output logic [clog2(N_REQ)-1:0]   rsp_id_o,
    output logic [DW-1:0]             rsp_data_o,
    output logic                      busy_o
);

    localparam int IW = clog2(N_REQ);

    logic [N_REQ-1:0]   grant;
    logic [IW-1:0]      grant_idx;
    logic [IW-1:0]      ptr;
    logic               accept;
    logic [AW-1:0]      addr_arr [N_REQ];
    logic [AW-1:0]      last_addr;
    logic [ROM_LAT-1:0] stg_vld;
    logic [IW-1:0]      stg_id [ROM_LAT];
    logic [IW-1:0]      held_id;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr_i[g*AW +: AW];
    end

    // Grants are masked by reset so ready drops the instant rstn falls.
    assign req_ready_o = rstn ? grant : '0;
    assign accept      = |req_ready_o;
    assign lut_addr_o  = accept ? addr_arr[grant_idx] : last_addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            last_addr <= '0;
            stg_vld   <= '0;
            held_id   <= '0;
            for (int i = 0; i < ROM_LAT; i++) stg_id[i] <= '0;
        end else begin
            if (accept) begin
                ptr       <= (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + IW'(1);
                last_addr <= lut_addr_o;
            end
            // The ROM cannot stall, so the tag pipe shifts every cycle.
            stg_vld[0] <= accept;
            stg_id[0]  <= grant_idx;
            for (int i = 1; i < ROM_LAT; i++) begin
                stg_vld[i] <= stg_vld[i-1];
                stg_id[i]  <= stg_id[i-1];
            end
            if (stg_vld[ROM_LAT-1]) held_id <= stg_id[ROM_LAT-1];
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (stg_vld[ROM_LAT-1]) rsp_valid_o[stg_id[ROM_LAT-1]] = 1'b1;
    end

    assign rsp_id_o   = stg_vld[ROM_LAT-1] ? stg_id[ROM_LAT-1] : held_id;
    assign rsp_data_o = lut_data_i;
    assign busy_o     = |stg_vld;

endmodule
